// File: rtl/lcd_sequencer.sv
// Power-on initialisation, configuration and host write sequencing for a 4-bit character LCD.
// Drives the LCD nibble pins directly during init, then hands byte transfers to the nibble transmitter.
module lcd_sequencer #(
   parameter int T_POWERUP = 750000,
   parameter int T_INIT1   = 205000,
   parameter int T_INIT2   = 5000,
   parameter int T_CMD     = 2000,
   parameter int T_CLEAR   = 82000,
   parameter int T_EHOLD   = 12,
   parameter int CW        = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       wr_rs,
   input  logic [7:0] wr_data,
   output logic       tx_start,
   output logic [9:0] tx_data,
   input  logic       tx_done,
   output logic       nib_sel,
   output logic       nib_e,
   output logic [3:0] nib_d,
   output logic       init_done
);

   typedef enum logic [3:0] {
      PWR_WAIT,
      INIT_NIB,
      INIT_GAP,
      CFG_SEND,
      CFG_WAIT,
      IDLE,
      HOST_SEND,
      HOST_WAIT,
      LONG_WAIT
   } state_t;

   // Terminal counter values: a wait of N cycles ends when the counter reads N-1.
   localparam logic [CW-1:0] PWR_LAST   = CW'(T_POWERUP - 1);
   localparam logic [CW-1:0] INIT1_LAST = CW'(T_INIT1 - 1);
   localparam logic [CW-1:0] INIT2_LAST = CW'(T_INIT2 - 1);
   localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(T_CLEAR - 1);
   localparam logic [CW-1:0] NIB_LAST   = CW'(T_EHOLD + 1);
   localparam logic [CW-1:0] EHOLD_END  = CW'(T_EHOLD);

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic [1:0]    step, step_next;
   logic [1:0]    cfg_idx, cfg_idx_next;
   logic [8:0]    word, word_next;
   logic          init_done_next;
   logic [CW-1:0] wait_last;
   logic          cnt_last;
   logic [7:0]    cfg_byte;
   logic          long_cmd;

   function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   // NOTE: non-blocking assignments so every register samples pre-edge values together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= PWR_WAIT;
         cnt       <= '0;
         step      <= 2'd0;
         cfg_idx   <= 2'd0;
         word      <= 9'd0;
         init_done <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= (state_next != state) ? '0 : cnt + CW'(1);
         step      <= step_next;
         cfg_idx   <= cfg_idx_next;
         word      <= word_next;
         init_done <= init_done_next;
      end
   end

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_next     = state;
      step_next      = step;
      cfg_idx_next   = cfg_idx;
      word_next      = word;
      init_done_next = init_done;
      wr_ready       = 1'b0;
      tx_start       = 1'b0;
      tx_data        = 10'd0;
      nib_sel        = 1'b0;
      nib_e          = 1'b0;
      nib_d          = 4'h0;
      wait_last      = '0;

      cfg_byte = cfg_rom(cfg_idx);
      long_cmd = !word[8] && (word[7:2] == 6'd0) && (word[1:0] != 2'd0);

      case (state)
         PWR_WAIT:  wait_last = PWR_LAST;
         INIT_NIB:  wait_last = NIB_LAST;
         INIT_GAP: begin
            case (step)
               2'd0:    wait_last = INIT1_LAST;
               2'd1:    wait_last = INIT2_LAST;
               default: wait_last = CMD_LAST;
            endcase
         end
         LONG_WAIT: wait_last = CLEAR_LAST;
         default:   wait_last = '0;
      endcase
      cnt_last = (cnt == wait_last);

      case (state)
         PWR_WAIT: begin
            nib_sel = 1'b1;
            if (cnt_last) begin
               state_next = INIT_NIB;
               step_next  = 2'd0;
            end
         end
         INIT_NIB: begin
            nib_sel = 1'b1;
            nib_d   = (step == 2'd3) ? 4'h2 : 4'h3;
            // Data is set up one cycle before E rises and held one cycle after it falls.
            nib_e   = (cnt != '0) && (cnt <= EHOLD_END);
            if (cnt_last) state_next = INIT_GAP;
         end
         INIT_GAP: begin
            nib_sel = 1'b1;
            nib_d   = (step == 2'd3) ? 4'h2 : 4'h3;
            if (cnt_last) begin
               step_next = step + 2'd1;
               if (step == 2'd3) begin
                  state_next   = CFG_SEND;
                  cfg_idx_next = 2'd0;
               end else begin
                  state_next = INIT_NIB;
               end
            end
         end
         CFG_SEND: begin
            tx_start   = 1'b1;
            tx_data    = {2'b00, cfg_byte};
            state_next = CFG_WAIT;
         end
         CFG_WAIT: begin
            tx_data = {2'b00, cfg_byte};
            if (tx_done) begin
               if (cfg_byte == 8'h01) begin
                  state_next = LONG_WAIT;
               end else if (cfg_idx == 2'd3) begin
                  init_done_next = 1'b1;
                  state_next     = IDLE;
               end else begin
                  cfg_idx_next = cfg_idx + 2'd1;
                  state_next   = CFG_SEND;
               end
            end
         end
         IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               word_next  = {wr_rs, wr_data};
               state_next = HOST_SEND;
            end
         end
         HOST_SEND: begin
            tx_start   = 1'b1;
            tx_data    = {word[8], 1'b0, word[7:0]};
            state_next = HOST_WAIT;
         end
         HOST_WAIT: begin
            tx_data = {word[8], 1'b0, word[7:0]};
            if (tx_done) state_next = long_cmd ? LONG_WAIT : IDLE;
         end
         LONG_WAIT: begin
            tx_data = init_done ? {word[8], 1'b0, word[7:0]} : {2'b00, cfg_byte};
            if (cnt_last) begin
               // Clear/Home can come from the config ROM or from the host.
               if (init_done) begin
                  state_next = IDLE;
               end else if (cfg_idx == 2'd3) begin
                  init_done_next = 1'b1;
                  state_next     = IDLE;
               end else begin
                  cfg_idx_next = cfg_idx + 2'd1;
                  state_next   = CFG_SEND;
               end
            end
         end
         default: state_next = PWR_WAIT;
      endcase
   end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: scoreboard of init nibbles and transmitter words,
// with a transmitter model that returns tx_done a fixed latency after each tx_start.
module tb_lcd_sequencer;

   localparam int TP     = 40;
   localparam int TI1    = 30;
   localparam int TI2    = 20;
   localparam int TCM    = 10;
   localparam int TC     = 50;
   localparam int TE     = 3;
   localparam int TX_LAT = 2000;

   typedef struct {
      int         cyc;
      logic [3:0] nib;
   } nib_ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_rs = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       tx_done = 1'b0;
   logic       wr_ready, tx_start, nib_sel, nib_e, init_done;
   logic [9:0] tx_data;
   logic [3:0] nib_d;

   int errors = 0;
   int checks = 0;

   nib_ev_t    nib_q[$];
   logic [9:0] tx_q[$];
   nib_ev_t    ev;
   logic [9:0] cur;
   int  cyc, countdown, exp_resume, exp_start, exp_sel_fall, e_rise, tx_count;
   int  inject_req = 0;
   int  inject_seen = 0;
   bit  busy, resume_pend, host_pend;
   logic nib_e_q, nib_sel_q, wr_ready_q, init_done_q;

   always #10 clk = ~clk;

   lcd_sequencer #(
      .T_POWERUP(TP), .T_INIT1(TI1), .T_INIT2(TI2), .T_CMD(TCM),
      .T_CLEAR(TC), .T_EHOLD(TE), .CW(20)
   ) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_rs(wr_rs), .wr_data(wr_data), .tx_start(tx_start), .tx_data(tx_data),
      .tx_done(tx_done), .nib_sel(nib_sel), .nib_e(nib_e), .nib_d(nib_d),
      .init_done(init_done)
   );

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic bit is_long(input logic [9:0] w);
      return !w[9] && (w[7:0] >= 8'h01) && (w[7:0] <= 8'h03);
   endfunction

   // Transmitter model plus monitor in one process so tx_done and the checks never race.
   always @(negedge clk) begin
      if (reset) begin
         nib_q.delete();
         tx_q.delete();
         cyc = 0; busy = 0; countdown = 0; tx_done = 1'b0;
         resume_pend = 0; host_pend = 0; inject_seen = inject_req;
         nib_e_q = 1'b0; nib_sel_q = 1'b1; wr_ready_q = 1'b0; init_done_q = 1'b0;
      end else begin
         tx_done = 1'b0;
         if (inject_req != inject_seen) begin
            tx_done = 1'b1;
            inject_seen = inject_req;
         end
         if (busy && countdown > 0) begin
            countdown--;
            if (countdown == 0) tx_done = 1'b1;
         end

         if (nib_e && !nib_e_q) begin
            if (nib_q.size() == 0) check("nib_extra_pulse", 1, 0);
            else begin
               ev = nib_q.pop_front();
               check("nib_rise_cyc", cyc, ev.cyc);
               check("nib_d", nib_d, ev.nib);
            end
            check("nib_sel_in_init", nib_sel, 1);
            e_rise = cyc;
         end
         if (!nib_e && nib_e_q) check("nib_e_width", cyc - e_rise, TE);
         if (!nib_sel && nib_sel_q) begin
            check("nib_sel_fall_cyc", cyc, exp_sel_fall);
            check("cfg_first_start", tx_start, 1);
            check("nib_pulses_left", nib_q.size(), 0);
         end
         if (init_done && !init_done_q)
            check("init_done_cyc", cyc, resume_pend ? exp_resume : -1);
         if (wr_ready && !wr_ready_q && resume_pend) begin
            check("ready_resume_cyc", cyc, exp_resume);
            resume_pend = 0;
         end

         if (tx_start) begin
            tx_count++;
            check("tx_busy", busy, 0);
            if (resume_pend) begin
               check("cfg_next_cyc", cyc, exp_resume);
               resume_pend = 0;
            end
            if (host_pend) begin
               check("host_latency", cyc, exp_start);
               check("ready_drop", wr_ready, 0);
               host_pend = 0;
            end
            if (tx_q.size() == 0) check("tx_extra_start", 1, 0);
            else begin
               cur = tx_q.pop_front();
               check("tx_data", tx_data, cur);
            end
            busy = 1;
            countdown = TX_LAT;
         end else if (tx_done && busy) begin
            check("tx_data_stable", tx_data, cur);
            busy = 0;
            exp_resume = cyc + (is_long(cur) ? TC + 1 : 1);
            resume_pend = 1;
         end

         if (wr_valid && wr_ready) begin
            tx_q.push_back({wr_rs, 1'b0, wr_data});
            host_pend = 1;
            exp_start = cyc + 1;
         end
         cyc++;
         nib_e_q = nib_e; nib_sel_q = nib_sel; wr_ready_q = wr_ready; init_done_q = init_done;
      end
   end

   task automatic push_init_expect();
      int c;
      c = TP + 1;
      nib_q.push_back('{c, 4'h3});
      c += TE + 2 + TI1;
      nib_q.push_back('{c, 4'h3});
      c += TE + 2 + TI2;
      nib_q.push_back('{c, 4'h3});
      c += TE + 2 + TCM;
      nib_q.push_back('{c, 4'h2});
      exp_sel_fall = c + TE + 1 + TCM;
      tx_q.push_back(10'h028);
      tx_q.push_back(10'h006);
      tx_q.push_back(10'h00C);
      tx_q.push_back(10'h001);
   endtask

   task automatic apply_reset(input string tag);
      @(posedge clk); #1;
      reset = 1'b1;
      wr_valid = 1'b0;
      #1;
      check({tag, "_wr_ready"}, wr_ready, 0);
      check({tag, "_tx_start"}, tx_start, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_nib_sel"}, nib_sel, 1);
      check({tag, "_nib_e"}, nib_e, 0);
      check({tag, "_nib_d"}, nib_d, 0);
      check({tag, "_init_done"}, init_done, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      push_init_expect();
   endtask

   task automatic host_write(input logic rs, input logic [7:0] d);
      bit got;
      got = 0;
      wr_rs = rs;
      wr_data = d;
      wr_valid = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (wr_ready) begin
            got = 1;
            break;
         end
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      if (!got) check("host_accept_timeout", 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit got;
      got = 0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk); #1;
         if (wr_ready && init_done && !busy) begin
            got = 1;
            break;
         end
      end
      if (!got) check({tag, "_idle_timeout"}, 0, 1);
   endtask

   initial begin
      int n;
      apply_reset("rst0");
      wait_idle("init0");
      check("cfg_all_sent", tx_q.size(), 0);

      host_write(1'b1, 8'h41);
      wait_idle("h41");
      host_write(1'b0, 8'h01);
      wait_idle("h01");
      host_write(1'b0, 8'h80);
      wait_idle("h80");

      n = tx_count;
      inject_req++;
      repeat (6) @(posedge clk);
      #1;
      check("stray_done_ready", wr_ready, 1);
      check("stray_done_no_start", tx_count, n);
      check("stray_done_init", init_done, 1);

      host_write(1'b1, 8'h42);
      repeat (100) @(posedge clk);
      #1;
      check("mid_host_wait_busy", busy, 1);
      apply_reset("rst_hwait");

      host_write(1'b1, 8'h55);
      wait_idle("init1");
      check("one_xfer_per_hs", tx_q.size(), 0);

      apply_reset("rst_re");
      repeat (TP + TE + 12) @(posedge clk);
      #1;
      check("in_gap_nib_sel", nib_sel, 1);
      check("in_gap_pulses_left", nib_q.size(), 3);
      apply_reset("rst_gap");
      wait_idle("init2");
      check("cfg2_all_sent", tx_q.size(), 0);
      check("nib2_all_seen", nib_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Top-level controller for the 4-bit character LCD path; sits between host logic and the byte-level nibble transmitter.
- After reset, runs the LCD power-on initialisation by driving the LCD nibble pins directly.
- Then issues the configuration byte sequence through the transmitter, and finally accepts host command/character writes over a valid/ready handshake, enforcing every post-command delay.

Parameters:
- T_POWERUP, 750000, cycles of initial power-up wait (15 ms at 50 MHz)
- T_INIT1, 205000, wait after first 0x3 nibble (4.1 ms)
- T_INIT2, 5000, wait after second 0x3 nibble (100 us)
- T_CMD, 2000, wait after third 0x3 and after 0x2 nibble (40 us)
- T_CLEAR, 82000, extra wait after Clear (0x01) or Return Home (0x02/0x03) commands (1.64 ms)
- T_EHOLD, 12, LCD_E high width in cycles for init nibbles
- CW, 20, wait counter width; must hold T_POWERUP

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- wr_valid  in  1  host write request
- wr_ready  out  1  sequencer accepts a host write this cycle
- wr_rs  in  1  0 = command, 1 = character data
- wr_data  in  8  command/character byte
- tx_start  out  1  one-cycle pulse, starts a byte transfer in the transmitter
- tx_data  out  10  {RS, RW, D[7:0]} to transmitter; RW always 0
- tx_done  in  1  one-cycle pulse from transmitter, end of its byte cycle including its 40 us gap
- nib_sel  out  1  1 = LCD pins driven by this block (init phase); 0 = transmitter owns pins
- nib_e  out  1  LCD_E during init phase
- nib_d  out  4  DB7..DB4 during init phase
- init_done  out  1  high once configuration is complete; stays high until reset

Behaviour:
- Reset (asynchronous, any state, including mid-transfer): state=PWR_WAIT, counter=0, step=0; wr_ready=0, tx_start=0, tx_data=0, nib_sel=1, nib_e=0, nib_d=0, init_done=0.
- States: PWR_WAIT, INIT_NIB, INIT_GAP, CFG_SEND, CFG_WAIT, IDLE, HOST_SEND, HOST_WAIT, LONG_WAIT.
- PWR_WAIT: count to T_POWERUP-1, then go to INIT_NIB with step=0.
- INIT_NIB:
  - nib_d = 0x3 for steps 0-2 and 0x2 for step 3.
  - nib_d is valid from the first cycle; nib_e=1 on cycles 1..T_EHOLD of the state, then 0 for 1 cycle. This gives setup and hold of at least 1 cycle each.
  - Then go to INIT_GAP.
- INIT_GAP:
  - Wait length: step 0 -> T_INIT1; step 1 -> T_INIT2; steps 2 and 3 -> T_CMD.
  - After the wait, step increments. After step 3, go to CFG_SEND with cfg index 0 and nib_sel=0; otherwise return to INIT_NIB.
- Configuration ROM, RS=0: 0x28 (function set), 0x06 (entry mode), 0x0C (display on), 0x01 (clear).
- CFG_SEND: tx_data={0,0,byte}, tx_start pulses for exactly 1 cycle, then go to CFG_WAIT.
- CFG_WAIT: hold tx_data stable until tx_done.
  - If the byte was 0x01, go to LONG_WAIT before the next byte.
  - After the 4th byte and its wait, set init_done=1 and go to IDLE.
- IDLE: wr_ready=1. On wr_valid&&wr_ready, latch {wr_rs,wr_data}, drop wr_ready next cycle, and go to HOST_SEND.
- HOST_SEND/HOST_WAIT: same as CFG_SEND/CFG_WAIT for the latched word.
  - A command with wr_rs=0 and wr_data in {0x01,0x02,0x03} goes through LONG_WAIT (T_CLEAR cycles).
  - Otherwise return directly to IDLE on the cycle after tx_done.
- wr_ready is 0 in every state except IDLE. Host writes presented while not ready are ignored and not queued.
- tx_done arriving outside CFG_WAIT/HOST_WAIT is ignored.
- tx_start is never asserted while a prior transfer is outstanding.
- Counter: CW bits, reset to 0 on every state entry, compared with terminal value minus 1. A wait of N cycles occupies exactly N cycles.
- Host latency: accept at cycle A -> tx_start at A+1.

Test Plan:
- Reset release, no host traffic.
  - nib_e pulses occur exactly 4 times: first rising edge at cycle T_POWERUP+1; gaps T_INIT1/T_INIT2/T_CMD/T_CMD; nib_d 3,3,3,2.
  - nib_sel then falls.
- Config phase with a transmitter model returning tx_done 2000 cycles after tx_start.
  - tx_data sequence is 0x028, 0x006, 0x00C, 0x001.
  - T_CLEAR cycles elapse between tx_done of 0x001 and init_done=1.
- Host writes rs=1 data=0x41 in IDLE -> wr_ready drops, tx_start at the next cycle with tx_data=0x241, wr_ready back high one cycle after tx_done.
- Host command rs=0 data=0x01 -> after tx_done, wr_ready stays 0 for T_CLEAR cycles; then rs=0 0x80 returns without long wait.
- wr_valid held high throughout init -> no tx_start with a host word before init_done. Exactly one transfer per accepted handshake; an extra tx_done pulse injected in IDLE has no effect.
- Reset asserted mid HOST_WAIT and mid INIT_GAP -> all outputs return to reset values immediately; full init sequence restarts from PWR_WAIT.
